// File: rtl/oled_init_seq.sv
`timescale 1ns/1ps
// OLED power-up and initialisation sequencer.
// Runs the panel reset pulse (hold high, drive low, release), then writes a
// fixed register table to the downstream I2C master one command at a time.
// Failed writes (NACK or no completion within TIMEOUT) are retried up to
// RETRY_MAX attempts in total. The sequence ends in DONE or ERROR.
//
// Command handshake: the payload (cmd_slv_addr_o, cmd_reg_addr_o, cmd_data_o,
// cmd_rw_o, cmd_idx_o) is valid and held stable whenever cmd_valid_o=1; a
// transfer happens on every rising edge where cmd_valid_o & cmd_ready_i, and
// cmd_valid_o is low in the following cycle. cmd_valid_o never drops without
// a transfer, except on asynchronous reset.
module oled_init_seq #(
  parameter int unsigned DELAY     = 1500000,
  parameter int unsigned GAP       = 150,
  parameter int unsigned TIMEOUT   = 4000000,
  parameter int unsigned RETRY_MAX = 3,
  parameter int unsigned NUM_CMDS  = 4,
  parameter logic [6:0]  SLV_ADDR  = 7'b1010100
) (
  input  logic       sys_clk_i,
  input  logic       rst_n,
  input  logic       restart_i,
  output logic       oled_rst_o,
  output logic       cmd_valid_o,
  input  logic       cmd_ready_i,
  output logic [6:0] cmd_slv_addr_o,
  output logic [7:0] cmd_reg_addr_o,
  output logic [7:0] cmd_data_o,
  output logic       cmd_rw_o,
  input  logic       done_i,
  input  logic       ack_err_i,
  output logic [3:0] cmd_idx_o,
  output logic       init_done_o,
  output logic       init_err_o,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    S_PWR_WAIT  = 3'd0,
    S_RST_LOW   = 3'd1,
    S_RST_REL   = 3'd2,
    S_ISSUE     = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_GAP       = 3'd5,
    S_DONE      = 3'd6,
    S_ERROR     = 3'd7
  } state_t;

  localparam logic [23:0] DLY_LAST  = 24'(DELAY - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP - 1);
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT - 1);
  localparam logic [3:0]  IDX_LAST  = 4'(NUM_CMDS - 1);
  localparam logic [2:0]  RETRY_LIM = 3'(RETRY_MAX);

  state_t      r_state;
  logic [23:0] r_cnt;        // shared by the reset phases and the inter-command gap
  logic [23:0] r_tmo;
  logic [1:0]  r_retry;
  logic [3:0]  r_idx;
  logic        r_oled_rst;
  logic        r_cmd_valid;
  logic [6:0]  r_slv_addr;
  logic [7:0]  r_reg_addr;
  logic [7:0]  r_data;
  logic        r_init_done;
  logic        r_init_err;

  logic [15:0] w_rom;
  logic [15:0] w_rom0;
  logic [2:0]  w_retry_nxt;
  logic        w_ok;
  logic        w_fail;

  // Register table: {register address, data}; unused entries write 0 to 0.
  function automatic logic [15:0] rom(input logic [3:0] idx);
    case (idx)
      4'd0:    rom = 16'h010B;
      4'd1:    rom = 16'h0200;
      4'd2:    rom = 16'h0310;
      4'd3:    rom = 16'h0401;
      default: rom = 16'h0000;
    endcase
  endfunction

  assign w_rom  = rom(r_idx);
  assign w_rom0 = rom(4'd0);

  // Attempt outcome in WAIT_DONE: a completion pulse wins over the timeout.
  assign w_retry_nxt = {1'b0, r_retry} + 3'd1;
  assign w_ok        = done_i & ~ack_err_i;
  assign w_fail      = done_i ? ack_err_i : (r_tmo == TMO_LAST);

  // Sequencer: reset pulse, command issue/retry, terminal states.
  always_ff @(posedge sys_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_PWR_WAIT;
      r_cnt       <= '0;
      r_tmo       <= '0;
      r_retry     <= '0;
      r_idx       <= '0;
      r_oled_rst  <= 1'b1;
      r_cmd_valid <= 1'b0;
      r_slv_addr  <= '0;
      r_reg_addr  <= '0;
      r_data      <= '0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
    end else begin
      case (r_state)
        S_PWR_WAIT: begin
          r_oled_rst <= 1'b1;
          if (r_cnt == DLY_LAST) begin
            r_cnt      <= '0;
            r_oled_rst <= 1'b0;
            r_state    <= S_RST_LOW;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_RST_LOW: begin
          if (r_cnt == DLY_LAST) begin
            r_cnt      <= '0;
            r_oled_rst <= 1'b1;
            r_state    <= S_RST_REL;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_RST_REL: begin
          if (r_cnt == DLY_LAST) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_cmd_valid <= 1'b1;
            r_slv_addr  <= SLV_ADDR;
            r_reg_addr  <= w_rom0[15:8];
            r_data      <= w_rom0[7:0];
            r_state     <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_ISSUE: begin
          // Payload registers are untouched here, so they hold under backpressure.
          if (cmd_ready_i) begin
            r_cmd_valid <= 1'b0;
            r_tmo       <= '0;
            r_state     <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (w_ok) begin
            if (r_idx == IDX_LAST) begin
              r_init_done <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_idx   <= r_idx + 4'd1;
              r_retry <= '0;
              r_cnt   <= '0;
              r_state <= S_GAP;
            end
          end else if (w_fail) begin
            r_retry <= w_retry_nxt[1:0];
            if (w_retry_nxt == RETRY_LIM) begin
              r_init_err <= 1'b1;
              r_state    <= S_ERROR;
            end else begin
              r_cnt   <= '0;
              r_state <= S_GAP;
            end
          end else begin
            r_tmo <= r_tmo + 24'd1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_cnt       <= '0;
            r_cmd_valid <= 1'b1;
            r_slv_addr  <= SLV_ADDR;
            r_reg_addr  <= w_rom[15:8];
            r_data      <= w_rom[7:0];
            r_state     <= S_ISSUE;
          end else begin
            r_cnt <= r_cnt + 24'd1;
          end
        end
        S_DONE, S_ERROR: begin
          r_oled_rst <= 1'b1;
          if (restart_i) begin
            r_init_done <= 1'b0;
            r_init_err  <= 1'b0;
            r_idx       <= '0;
            r_retry     <= '0;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_state     <= S_PWR_WAIT;
          end
        end
        default: begin
          r_state <= S_PWR_WAIT;
        end
      endcase
    end
  end

  assign oled_rst_o     = r_oled_rst;
  assign cmd_valid_o    = r_cmd_valid;
  assign cmd_slv_addr_o = r_slv_addr;
  assign cmd_reg_addr_o = r_reg_addr;
  assign cmd_data_o     = r_data;
  assign cmd_rw_o       = 1'b0;
  assign cmd_idx_o      = r_idx;
  assign init_done_o    = r_init_done;
  assign init_err_o     = r_init_err;
  assign dbg_state_o    = r_state;

endmodule

// File: tb/tb_oled_init_seq.sv
`timescale 1ns/1ps
// Bench for oled_init_seq: table of response scenarios with hand-computed
// outcomes, randomized scenarios checked against a command-level model, and
// hand sequences for restart, restart-during-reset and async reset.
module tb_oled_init_seq;

  localparam int DELAY     = 10;
  localparam int GAP       = 4;
  localparam int TIMEOUT   = 50;
  localparam int RETRY_MAX = 3;
  localparam int NUM_CMDS  = 4;
  localparam logic [6:0] SLV = 7'h54;

  localparam int K_ACK  = 0;
  localparam int K_NACK = 1;
  localparam int K_SIL  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic restart = 1'b0;
  logic ready = 1'b0;
  logic done = 1'b0;
  logic ack_err = 1'b0;

  logic       oled_rst_o, cmd_valid_o, cmd_rw_o, init_done_o, init_err_o;
  logic [6:0] cmd_slv_addr_o;
  logic [7:0] cmd_reg_addr_o, cmd_data_o;
  logic [3:0] cmd_idx_o;
  logic [2:0] dbg_state_o;

  always #5 clk = ~clk;

  oled_init_seq #(
    .DELAY(DELAY), .GAP(GAP), .TIMEOUT(TIMEOUT), .RETRY_MAX(RETRY_MAX),
    .NUM_CMDS(NUM_CMDS), .SLV_ADDR(7'b1010100)
  ) dut (
    .sys_clk_i(clk), .rst_n(rst_n), .restart_i(restart),
    .oled_rst_o(oled_rst_o), .cmd_valid_o(cmd_valid_o), .cmd_ready_i(ready),
    .cmd_slv_addr_o(cmd_slv_addr_o), .cmd_reg_addr_o(cmd_reg_addr_o),
    .cmd_data_o(cmd_data_o), .cmd_rw_o(cmd_rw_o), .done_i(done),
    .ack_err_i(ack_err), .cmd_idx_o(cmd_idx_o), .init_done_o(init_done_o),
    .init_err_o(init_err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];          // {idx, reg, data} per expected attempt
  logic [15:0] ref_rom [NUM_CMDS] = '{16'h010B, 16'h0200, 16'h0310, 16'h0401};
  int kind_q[$];
  int dly_q[$];
  int stall_q[$];
  bit m_done, m_err;
  int m_idx, m_attempts;
  int g_att;

  typedef struct packed {
    logic [3:0]  n;
    logic [15:0] kinds;      // 2 bits per attempt, attempt 0 in [1:0]
    logic [3:0]  stall0;
    logic        exp_done;
    logic        exp_err;
    logic [3:0]  exp_idx;
    logic [3:0]  exp_att;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Walks the response plan with the retry rules and predicts every attempt.
  task automatic run_model();
    int idx, tries, k, kind;
    idx = 0; tries = 0; k = 0;
    exp_q.delete(); m_done = 0; m_err = 0;
    while (!m_done && !m_err && k < 64) begin
      kind = (k < kind_q.size()) ? kind_q[k] : K_ACK;
      exp_q.push_back({4'(idx), ref_rom[idx]});
      k++;
      if (kind == K_ACK) begin
        if (idx == NUM_CMDS - 1) m_done = 1;
        else begin idx++; tries = 0; end
      end else begin
        tries++;
        if (tries == RETRY_MAX) m_err = 1;
      end
    end
    m_idx = idx;
    m_attempts = k;
  endtask

  // ---------------- driver tasks ----------------
  // Measures the three reset phases; optionally pulses restart_i in RST_LOW.
  task automatic pwr_check(input bit restart_in_low);
    int hi, lo, hi2;
    hi = 0; lo = 0; hi2 = 0;
    while (oled_rst_o === 1'b1 && hi < 100) begin hi++; @(negedge clk); end
    check("pwr_wait_cycles", 32'(hi), 32'(DELAY));
    while (oled_rst_o === 1'b0 && lo < 100) begin
      lo++;
      restart = restart_in_low && (lo == 3);
      check("valid_in_rst_low", 32'(cmd_valid_o), 32'd0);
      @(negedge clk);
    end
    restart = 1'b0;
    check("rst_low_cycles", 32'(lo), 32'(DELAY));
    while (oled_rst_o === 1'b1 && cmd_valid_o !== 1'b1 && hi2 < 100) begin hi2++; @(negedge clk); end
    check("rst_rel_cycles", 32'(hi2), 32'(DELAY));
    check("issue_after_rel", 32'(cmd_valid_o), 32'd1);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_done_clr", 32'(init_done_o), 32'd0);
    check("restart_err_clr", 32'(init_err_o), 32'd0);
    check("restart_idx_clr", 32'(cmd_idx_o), 32'd0);
  endtask

  // Acts as the I2C master for every attempt, following the response plan.
  task automatic run_cmds();
    int k, kind, dly, stall, low, exp_low;
    logic [19:0] got, expv;
    bit fin, last, stop;
    k = 0; fin = 0;
    while (!fin) begin
      kind  = (k < kind_q.size())  ? kind_q[k]  : K_ACK;
      dly   = (k < dly_q.size())   ? dly_q[k]   : 5;
      stall = (k < stall_q.size()) ? stall_q[k] : 0;
      check("issue_valid", 32'(cmd_valid_o), 32'd1);
      check("slv_addr", 32'(cmd_slv_addr_o), 32'(SLV));
      check("rw", 32'(cmd_rw_o), 32'd0);
      got = {cmd_idx_o, cmd_reg_addr_o, cmd_data_o};
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL extra_cmd: got %h required no further command", got);
        fin = 1;
      end else begin
        expv = exp_q.pop_front();
        last = (exp_q.size() == 0);
        check("payload", 32'(got), 32'(expv));
        ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check("stall_valid", 32'(cmd_valid_o), 32'd1);
          check("stall_payload", 32'({cmd_idx_o, cmd_reg_addr_o, cmd_data_o}), 32'(got));
        end
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("valid_drop", 32'(cmd_valid_o), 32'd0);
        low = 0; stop = 0;
        while (!stop) begin
          if (cmd_valid_o || init_done_o || init_err_o || low >= 400) stop = 1;
          else begin
            low++;
            done    = (kind != K_SIL) && (low == dly);
            ack_err = done && (kind == K_NACK);
            @(negedge clk);
          end
        end
        done = 1'b0; ack_err = 1'b0;
        exp_low = ((kind == K_SIL) ? TIMEOUT : dly) + (last ? 0 : GAP);
        check("idle_cycles", 32'(low), 32'(exp_low));
        k++;
        if (init_done_o || init_err_o || !cmd_valid_o) fin = 1;
      end
    end
    g_att = k;
    check("attempt_count", 32'(k), 32'(m_attempts));
    check("final_done", 32'(init_done_o), 32'(m_done));
    check("final_err", 32'(init_err_o), 32'(m_err));
    check("final_idx", 32'(cmd_idx_o), 32'(m_idx));
    // Terminal state must hold; a stray done_i pulse is ignored.
    for (int h = 0; h < 10; h++) begin
      done = (h == 2);
      @(negedge clk);
      done = 1'b0;
      if (h == 9) begin
        check("hold_valid", 32'(cmd_valid_o), 32'd0);
        check("hold_flags", 32'({init_done_o, init_err_o}), 32'({m_done, m_err}));
        check("hold_idx", 32'(cmd_idx_o), 32'(m_idx));
        check("hold_oled_rst", 32'(oled_rst_o), 32'd1);
      end
    end
  endtask

  task automatic load_row(input vec_t v);
    kind_q.delete(); dly_q.delete(); stall_q.delete();
    for (int i = 0; i < int'(v.n); i++) begin
      kind_q.push_back(int'(v.kinds[2*i +: 2]));
      dly_q.push_back(5);
      stall_q.push_back((i == 0) ? int'(v.stall0) : 0);
    end
  endtask

  task automatic load_random();
    int n, r;
    kind_q.delete(); dly_q.delete(); stall_q.delete();
    n = $urandom_range(1, 10);
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 99);
      kind_q.push_back((r < 60) ? K_ACK : (r < 85) ? K_NACK : K_SIL);
      dly_q.push_back($urandom_range(1, 8));
      stall_q.push_back($urandom_range(0, 3));
    end
  endtask

  // ---------------- main test ----------------
  initial begin
    vecs[0] = '{n:4'd0, kinds:16'h0000, stall0:4'd0, exp_done:1'b1, exp_err:1'b0, exp_idx:4'd3, exp_att:4'd4};
    vecs[1] = '{n:4'd1, kinds:16'h0000, stall0:4'd7, exp_done:1'b1, exp_err:1'b0, exp_idx:4'd3, exp_att:4'd4};
    vecs[2] = '{n:4'd3, kinds:16'h0004, stall0:4'd0, exp_done:1'b1, exp_err:1'b0, exp_idx:4'd3, exp_att:4'd5};
    vecs[3] = '{n:4'd5, kinds:16'h0150, stall0:4'd0, exp_done:1'b0, exp_err:1'b1, exp_idx:4'd2, exp_att:4'd5};
    vecs[4] = '{n:4'd3, kinds:16'h002A, stall0:4'd0, exp_done:1'b0, exp_err:1'b1, exp_idx:4'd0, exp_att:4'd3};
    vecs[5] = '{n:4'd3, kinds:16'h0008, stall0:4'd0, exp_done:1'b1, exp_err:1'b0, exp_idx:4'd3, exp_att:4'd5};
    vecs[6] = '{n:4'd6, kinds:16'h0640, stall0:4'd0, exp_done:1'b0, exp_err:1'b1, exp_idx:4'd3, exp_att:4'd6};
    vecs[7] = '{n:4'd5, kinds:16'h0145, stall0:4'd0, exp_done:1'b1, exp_err:1'b0, exp_idx:4'd3, exp_att:4'd8};

    repeat (3) @(negedge clk);
    check("rst_oled_rst", 32'(oled_rst_o), 32'd1);
    check("rst_valid", 32'(cmd_valid_o), 32'd0);
    check("rst_payload", 32'({cmd_slv_addr_o, cmd_reg_addr_o, cmd_data_o, cmd_rw_o}), 32'd0);
    check("rst_idx", 32'(cmd_idx_o), 32'd0);
    check("rst_flags", 32'({init_done_o, init_err_o}), 32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < NV; r++) begin
      if (r > 0) do_restart();
      pwr_check(r == 4);
      load_row(vecs[r]);
      run_model();
      run_cmds();
      check("row_attempts", 32'(g_att), 32'(vecs[r].exp_att));
      check("row_done", 32'(init_done_o), 32'(vecs[r].exp_done));
      check("row_err", 32'(init_err_o), 32'(vecs[r].exp_err));
      check("row_idx", 32'(cmd_idx_o), 32'(vecs[r].exp_idx));
    end

    for (int t = 0; t < 8; t++) begin
      do_restart();
      pwr_check(1'b0);
      load_random();
      run_model();
      run_cmds();
    end

    // Async reset while a command is pending under backpressure.
    do_restart();
    pwr_check(1'b0);
    ready = 1'b0;
    @(negedge clk);
    check("pre_reset_valid", 32'(cmd_valid_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_valid", 32'(cmd_valid_o), 32'd0);
    check("async_oled_rst", 32'(oled_rst_o), 32'd1);
    check("async_idx", 32'(cmd_idx_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pwr_check(1'b0);
    load_row(vecs[0]);
    run_model();
    run_cmds();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard bound on run time.
  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
